// File: rtl/exec_monitor_pkg.sv
// Shared definitions for the execution monitor: FSM states, halt-reason
// codes and RV32 major opcodes (also used by the core's control decoder).
package exec_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] REASON_NONE  = 2'd0;
  localparam logic [1:0] REASON_HALT  = 2'd1;
  localparam logic [1:0] REASON_LIMIT = 2'd2;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_OTHER  = 3'd5
  } instr_class_t;

  // Map a major opcode onto exactly one instruction class.
  function automatic instr_class_t classify(input logic [6:0] opc);
    instr_class_t cls;
    case (opc)
      OPC_R:      cls = CLS_R;
      OPC_I:      cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      default:    cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/exec_monitor_trace_buffer.sv
// Circular trace of {pc, instr} pairs with a saturating valid count and
// newest-relative combinational read (index 0 = most recent write).
module trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [31:0]     wr_instr,
  input  logic [AW-1:0]   rd_idx,
  output logic [AW:0]     count,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr
);

  logic [XLEN+31:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;

  // Storage array: contents need no reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_pc, wr_instr};
  end

  // Write pointer wraps naturally (DEPTH is a power of two); count saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != (AW+1)'(DEPTH)) count <= count + 1'b1;
    end
  end

  // Newest-relative lookup; entries beyond the valid count read as zero.
  always_comb begin
    rd_addr  = wr_ptr - AW'(1) - rd_idx;
    rd_valid = ({1'b0, rd_idx} < count);
    rd_pc    = '0;
    rd_instr = '0;
    if (rd_valid) begin
      rd_pc    = mem[rd_addr][XLEN+31:32];
      rd_instr = mem[rd_addr][31:0];
    end
  end

endmodule

// File: rtl/exec_monitor.sv
// Execution monitor: samples the sequential core each RUN cycle, keeps
// saturating statistics, detects halt / cycle-limit and records a PC trace.
module exec_monitor
  import exec_monitor_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          MAX_CYCLES  = 50,
  parameter int          TRACE_DEPTH = 8,
  parameter logic [31:0] HALT_INSTR  = 32'h00000000,
  parameter int          CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [XLEN-1:0]                pc_in,
  input  logic [31:0]                    instr_in,
  input  logic [XLEN-1:0]                alu_in,
  input  logic                           reg_write_en,
  input  logic                           mem_write,
  input  logic                           branch,
  output logic                           running,
  output logic                           done,
  output logic [1:0]                     halt_reason,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               cnt_r,
  output logic [CNT_W-1:0]               cnt_i,
  output logic [CNT_W-1:0]               cnt_load,
  output logic [CNT_W-1:0]               cnt_store,
  output logic [CNT_W-1:0]               cnt_branch,
  output logic [CNT_W-1:0]               cnt_other,
  output logic [CNT_W-1:0]               cnt_reg_wr,
  output logic [CNT_W-1:0]               cnt_mem_wr,
  output logic [XLEN-1:0]                last_alu,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [XLEN-1:0]                trace_rd_pc,
  output logic [31:0]                    trace_rd_instr
);

  state_t           state, state_nxt;
  logic             sample;
  logic             clr;
  logic             is_halt;
  logic             at_limit;
  logic [CNT_W-1:0] cyc_inc;
  instr_class_t     cls;
  logic             unused_branch;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The branch strobe is part of the core interface but is not counted.
  assign unused_branch = branch;

  assign sample   = (state == ST_RUN);
  assign clr      = start && (state != ST_RUN);
  assign is_halt  = (instr_in == HALT_INSTR);
  assign cyc_inc  = sat_inc(cycle_count);
  assign at_limit = (cyc_inc == CNT_W'(MAX_CYCLES));
  assign cls      = classify(instr_in[6:0]);
  assign running  = (state == ST_RUN);
  assign done     = (state == ST_DONE);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start leaves IDLE/DONE; halt or cycle limit ends a run.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
      ST_RUN:           if (is_halt || at_limit) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Per-run statistics: cleared by an accepted start, updated each RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_reason <= REASON_NONE;
      cycle_count <= '0;
      cnt_r       <= '0;
      cnt_i       <= '0;
      cnt_load    <= '0;
      cnt_store   <= '0;
      cnt_branch  <= '0;
      cnt_other   <= '0;
      cnt_reg_wr  <= '0;
      cnt_mem_wr  <= '0;
      last_alu    <= '0;
    end else if (clr) begin
      halt_reason <= REASON_NONE;
      cycle_count <= '0;
      cnt_r       <= '0;
      cnt_i       <= '0;
      cnt_load    <= '0;
      cnt_store   <= '0;
      cnt_branch  <= '0;
      cnt_other   <= '0;
      cnt_reg_wr  <= '0;
      cnt_mem_wr  <= '0;
      last_alu    <= '0;
    end else if (sample) begin
      cycle_count <= cyc_inc;
      last_alu    <= alu_in;
      case (cls)
        CLS_R:      cnt_r      <= sat_inc(cnt_r);
        CLS_I:      cnt_i      <= sat_inc(cnt_i);
        CLS_LOAD:   cnt_load   <= sat_inc(cnt_load);
        CLS_STORE:  cnt_store  <= sat_inc(cnt_store);
        CLS_BRANCH: cnt_branch <= sat_inc(cnt_branch);
        default:    cnt_other  <= sat_inc(cnt_other);
      endcase
      if (reg_write_en) cnt_reg_wr <= sat_inc(cnt_reg_wr);
      if (mem_write)    cnt_mem_wr <= sat_inc(cnt_mem_wr);
      // Halt instruction takes priority over the cycle limit.
      if (is_halt)       halt_reason <= REASON_HALT;
      else if (at_limit) halt_reason <= REASON_LIMIT;
    end
  end

  trace_buffer #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .wr_en    (sample),
    .wr_pc    (pc_in),
    .wr_instr (instr_in),
    .rd_idx   (trace_rd_idx),
    .count    (trace_count),
    .rd_pc    (trace_rd_pc),
    .rd_instr (trace_rd_instr)
  );

endmodule

// File: tb/tb_exec_monitor.sv
// Directed plus randomized bench for exec_monitor against a queue-based
// behavioural model of a monitoring run.
module tb_exec_monitor;

  localparam int MAXC  = 50;
  localparam int DEPTH = 8;
  localparam int CMAX  = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0, alu_in = '0;
  logic        reg_write_en = 1'b0, mem_write = 1'b0, branch = 1'b0;
  logic        running, done;
  logic [1:0]  halt_reason;
  logic [15:0] cycle_count, cnt_r, cnt_i, cnt_load, cnt_store, cnt_branch, cnt_other;
  logic [15:0] cnt_reg_wr, cnt_mem_wr;
  logic [31:0] last_alu, trace_rd_pc, trace_rd_instr;
  logic [3:0]  trace_count;
  logic [2:0]  trace_rd_idx = '0;

  int checks = 0;
  int errors = 0;

  exec_monitor #(
    .XLEN(32), .MAX_CYCLES(MAXC), .TRACE_DEPTH(DEPTH),
    .HALT_INSTR(32'h00000000), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .instr_in(instr_in),
    .alu_in(alu_in), .reg_write_en(reg_write_en), .mem_write(mem_write),
    .branch(branch), .running(running), .done(done), .halt_reason(halt_reason),
    .cycle_count(cycle_count), .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_load(cnt_load),
    .cnt_store(cnt_store), .cnt_branch(cnt_branch), .cnt_other(cnt_other),
    .cnt_reg_wr(cnt_reg_wr), .cnt_mem_wr(cnt_mem_wr), .last_alu(last_alu),
    .trace_count(trace_count), .trace_rd_idx(trace_rd_idx),
    .trace_rd_pc(trace_rd_pc), .trace_rd_instr(trace_rd_instr)
  );

  always #10 clk = ~clk;

  // Behavioural model: flags, integer counts, newest-first trace queue.
  bit          m_running, m_done;
  int          m_reason, m_cyc, m_r, m_i, m_ld, m_st, m_br, m_oth, m_rw, m_mw;
  logic [31:0] m_alu;
  logic [63:0] m_trace[$];

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_running = 0; m_done = 0; m_reason = 0; m_cyc = 0;
    m_r = 0; m_i = 0; m_ld = 0; m_st = 0; m_br = 0; m_oth = 0; m_rw = 0; m_mw = 0;
    m_alu = '0; m_trace.delete();
  endtask

  task automatic model_edge(input bit st, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] alu, input bit rw, input bit mw);
    if (m_running) begin
      m_cyc = sat(m_cyc);
      case (ins[6:0])
        7'h33:   m_r   = sat(m_r);
        7'h13:   m_i   = sat(m_i);
        7'h03:   m_ld  = sat(m_ld);
        7'h23:   m_st  = sat(m_st);
        7'h63:   m_br  = sat(m_br);
        default: m_oth = sat(m_oth);
      endcase
      if (rw) m_rw = sat(m_rw);
      if (mw) m_mw = sat(m_mw);
      m_alu = alu;
      m_trace.push_front({pc, ins});
      if (m_trace.size() > DEPTH) void'(m_trace.pop_back());
      if (ins == 32'h0) begin
        m_running = 0; m_done = 1; m_reason = 1;
      end else if (m_cyc == MAXC) begin
        m_running = 0; m_done = 1; m_reason = 2;
      end
    end else if (st) begin
      model_reset();
      m_running = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] e;
    chk("running", 64'(running), 64'(m_running));
    chk("done", 64'(done), 64'(m_done));
    chk("halt_reason", 64'(halt_reason), 64'(m_reason));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("cnt_r", 64'(cnt_r), 64'(m_r));
    chk("cnt_i", 64'(cnt_i), 64'(m_i));
    chk("cnt_load", 64'(cnt_load), 64'(m_ld));
    chk("cnt_store", 64'(cnt_store), 64'(m_st));
    chk("cnt_branch", 64'(cnt_branch), 64'(m_br));
    chk("cnt_other", 64'(cnt_other), 64'(m_oth));
    chk("cnt_reg_wr", 64'(cnt_reg_wr), 64'(m_rw));
    chk("cnt_mem_wr", 64'(cnt_mem_wr), 64'(m_mw));
    chk("last_alu", 64'(last_alu), 64'(m_alu));
    chk("trace_count", 64'(trace_count), 64'(m_trace.size()));
    for (int k = 0; k < DEPTH; k++) begin
      trace_rd_idx = 3'(k);
      #1;
      e = (k < m_trace.size()) ? m_trace[k] : 64'h0;
      chk($sformatf("trace_pc[%0d]", k), 64'(trace_rd_pc), 64'(e[63:32]));
      chk($sformatf("trace_instr[%0d]", k), 64'(trace_rd_instr), 64'(e[31:0]));
    end
  endtask

  // One clock: drive inputs, step the model at the edge, check after it.
  task automatic cycle(input bit st, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] alu, input bit rw, input bit mw, input bit br);
    start = st; pc_in = pc; instr_in = ins; alu_in = alu;
    reg_write_en = rw; mem_write = mw; branch = br;
    @(posedge clk);
    model_edge(st, pc, ins, alu, rw, mw);
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_halt);
    logic [6:0] opc [7];
    logic [24:0] hi;
    opc[0] = 7'h33; opc[1] = 7'h13; opc[2] = 7'h03; opc[3] = 7'h23;
    opc[4] = 7'h63; opc[5] = 7'h37; opc[6] = 7'h6f;
    if (allow_halt && ($urandom_range(0, 15) == 0)) return 32'h0;
    hi = $urandom() | 25'h1;
    return {hi, opc[$urandom_range(0, 6)]};
  endfunction

  task automatic rcycle(input bit st, input bit allow_halt);
    cycle(st, $urandom(), rand_instr(allow_halt), $urandom(),
          1'($urandom()), 1'($urandom()), 1'($urandom()));
  endtask

  task automatic read_idx(input int k);
    trace_rd_idx = 3'(k);
    #1;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    chk("rst_trace_count", 64'(trace_count), 64'h0);
    #6 reset = 1'b1;

    // Mixed classes, halt at sixth sample.
    cycle(1, 32'h0, 32'h00000013, 32'h0, 0, 0, 0);
    chk("start_running", 64'(running), 64'h1);
    cycle(0, 32'h00, 32'h002081b3, 32'h11, 1, 0, 0);
    cycle(0, 32'h04, 32'h00500093, 32'h22, 1, 0, 0);
    cycle(0, 32'h08, 32'h0000a103, 32'h33, 1, 0, 0);
    cycle(0, 32'h0c, 32'h0020a023, 32'h44, 0, 1, 0);
    cycle(0, 32'h10, 32'h00208463, 32'h55, 0, 0, 1);
    cycle(0, 32'h14, 32'h00000000, 32'h66, 0, 0, 0);
    chk("t1_done", 64'(done), 64'h1);
    chk("t1_reason", 64'(halt_reason), 64'h1);
    chk("t1_cycles", 64'(cycle_count), 64'd6);
    chk("t1_r", 64'(cnt_r), 64'd1);
    chk("t1_other", 64'(cnt_other), 64'd1);
    chk("t1_last_alu", 64'(last_alu), 64'h66);
    rcycle(0, 1);
    chk("t1_done_hold", 64'(done), 64'h1);

    // Start in DONE clears, then run to the cycle limit with a stray start.
    rcycle(1, 0);
    chk("t2_clear_cycles", 64'(cycle_count), 64'h0);
    chk("t2_clear_trace", 64'(trace_count), 64'h0);
    chk("t2_running", 64'(running), 64'h1);
    for (int n = 1; n <= MAXC; n++) begin
      rcycle(n == 10, 0);
      if (n == 49) chk("t2_still_running", 64'(running), 64'h1);
    end
    chk("t2_reason", 64'(halt_reason), 64'h2);
    chk("t2_cycles", 64'(cycle_count), 64'd50);
    chk("t2_done", 64'(done), 64'h1);

    // Halt on the 50th sample wins over the limit.
    rcycle(1, 0);
    for (int n = 1; n < MAXC; n++) rcycle(0, 0);
    cycle(0, 32'h100, 32'h0, 32'h7, 0, 0, 0);
    chk("t3_reason", 64'(halt_reason), 64'h1);
    chk("t3_cycles", 64'(cycle_count), 64'd50);

    // Trace wraparound with 11 samples.
    rcycle(1, 0);
    for (int n = 0; n < 11; n++) cycle(0, 32'(n * 4), 32'h00100093, 32'(n), 0, 0, 0);
    chk("t4_trace_count", 64'(trace_count), 64'd8);
    read_idx(0);
    chk("t4_idx0_pc", 64'(trace_rd_pc), 64'h28);
    read_idx(7);
    chk("t4_idx7_pc", 64'(trace_rd_pc), 64'h0c);
    cycle(0, 32'h2c, 32'h0, 32'h0, 0, 0, 0);
    rcycle(1, 0);
    cycle(0, 32'h40, 32'h00100093, 32'h1, 0, 0, 0);
    cycle(0, 32'h44, 32'h00200093, 32'h2, 0, 0, 0);
    cycle(0, 32'h48, 32'h0, 32'h3, 0, 0, 0);
    for (int k = 3; k < DEPTH; k++) begin
      read_idx(k);
      chk("t4_empty_pc", 64'(trace_rd_pc), 64'h0);
    end

    // Asynchronous reset in the middle of a run.
    rcycle(1, 0);
    for (int n = 0; n < 20; n++) rcycle(0, 0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("t5_rst_running", 64'(running), 64'h0);
    chk("t5_rst_cycles", 64'(cycle_count), 64'h0);
    check_all();
    #2 reset = 1'b1;
    rcycle(1, 0);
    rcycle(0, 0);
    chk("t5_fresh_cycles", 64'(cycle_count), 64'd1);

    // Randomized traffic including random starts and halts.
    for (int n = 0; n < 400; n++) rcycle($urandom_range(0, 7) == 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exec_monitor.md
# exec_monitor

Synthesizable execution monitor for the sequential RISC-V core. It sits beside `seq_processor` and samples the core's per-cycle state: PC, instruction, ALU result, register-write, memory-write and branch. For each run it counts cycles and instruction classes, detects program completion by halt instruction or cycle limit, and keeps a circular trace of the last N executed PC/instruction pairs. It is the in-hardware, parametrised replacement for the cycle-loop-and-display bench checking.

## Interface
Parameters:
- `XLEN`, 32, width of PC and ALU result.
- `MAX_CYCLES`, 50, run cycle limit; must be ≥1 and < 2^CNT_W.
- `TRACE_DEPTH`, 8, trace entries; power of two, ≥2.
- `HALT_INSTR`, 32'h00000000, instruction word that ends a run.
- `CNT_W`, 16, width of every counter.

Ports:
- `clk`  in  1  core clock; everything samples on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run.
- `pc_in`  in  XLEN  core PC for the current cycle.
- `instr_in`  in  32  core instruction for the current cycle.
- `alu_in`  in  XLEN  core ALU output; captured as `last_alu`.
- `reg_write_en`, `mem_write`, `branch`  in  1 each  core control strobes.
- `running`  out  1  run in progress.
- `done`  out  1  run finished; held until the next `start`.
- `halt_reason`  out  2  0 none, 1 halt instruction, 2 cycle limit.
- `cycle_count`  out  CNT_W  cycles sampled in this run.
- `cnt_r`, `cnt_i`, `cnt_load`, `cnt_store`, `cnt_branch`, `cnt_other`  out  CNT_W each  instruction-class counts.
- `cnt_reg_wr`, `cnt_mem_wr`  out  CNT_W each  count of cycles with the corresponding strobe high.
- `last_alu`  out  XLEN  `alu_in` from the most recent sampled cycle.
- `trace_count`  out  $clog2(TRACE_DEPTH)+1  number of valid trace entries.
- `trace_rd_idx`  in  $clog2(TRACE_DEPTH)  trace read index; 0 is the newest entry.
- `trace_rd_pc`  out  XLEN  PC of the entry selected by `trace_rd_idx`.
- `trace_rd_instr`  out  32  instruction of the entry selected by `trace_rd_idx`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- In IDLE or DONE, `start` moves the FSM to RUN and clears all counters, `halt_reason`, `last_alu` and `trace_count`. `start` is ignored while in RUN.
- Each RUN cycle does the following:
  - increments `cycle_count`;
  - classifies `instr_in[6:0]`: 0110011 is R, 0010011 is I, 0000011 is load, 0100011 is store, 1100011 is branch, anything else is other. Exactly one class counter increments.
  - increments `cnt_reg_wr` if `reg_write_en` is high and `cnt_mem_wr` if `mem_write` is high (the `branch` input is sampled but not counted);
  - captures `alu_in` into `last_alu`;
  - writes {`pc_in`, `instr_in`} into the trace at the write pointer, advances the pointer modulo TRACE_DEPTH, overwriting the oldest entry once full, and increments `trace_count`, saturating at TRACE_DEPTH.
- Run termination. The terminating cycle is itself sampled and counted.
  - If `instr_in == HALT_INSTR`, go to DONE with `halt_reason` = 1.
  - Otherwise, if the incremented `cycle_count` equals MAX_CYCLES, go to DONE with `halt_reason` = 2.
  - If both conditions hold in the same cycle, the halt instruction wins (reason 1).
- Counters saturate at all-ones and never wrap.
- Trace read is combinational. Entry idx is at (wr_ptr − 1 − idx) mod TRACE_DEPTH. If idx ≥ `trace_count`, both read outputs are zero.
- In IDLE and DONE, all statistics hold their values.

## Timing
- Reset values: `running`=0, `done`=0, `halt_reason`=0, all counters 0, `last_alu`=0, `trace_count`=0, write pointer 0. Trace storage contents are don't-care.
- `start` sampled high at edge k: `running`=1 after edge k. The first core sample is taken at edge k+1.
- Terminating sample at edge m: after edge m, `running`=0, `done`=1 and all final values are visible. `done` stays high until the edge after the next `start`.
- Reset asserted mid-run clears everything immediately, without waiting for a clock edge.
- Trace read has zero-cycle latency from `trace_rd_idx` and from any state update.

## Structure
- A shared package `exec_monitor_pkg` holds:
  - the FSM state encoding;
  - the `halt_reason` encodings;
  - the RV32 opcode constants. The opcode constants are shared with the core's control decoder.
- Sub-module `trace_buffer`: a TRACE_DEPTH × (XLEN+32) circular register array with write pointer, saturating count and newest-relative read indexing.

## Test plan
- Core feeds R, I, load, store and branch opcodes, then 32'h00000000 at the 6th sample → `done`=1, `halt_reason`=1, `cycle_count`=6, each class counter =1, `cnt_other`=1.
- MAX_CYCLES=50 with no halt instruction → `done` after the 50th sample, `halt_reason`=2, `cycle_count`=50.
- TRACE_DEPTH=8 and 11 samples with PC 0x00,0x04,…,0x28 → `trace_count`=8; idx0 PC=0x28, idx7 PC=0x0C; 3 samples then halt → idx3..7 read 0.
- Halt instruction on the 50th sample with MAX_CYCLES=50 → `halt_reason`=1.
- Reset driven low mid-run at cycle 20 → all outputs 0 immediately. A following `start` gives a clean run with `cycle_count` starting at 1.
- `start` pulsed during RUN → ignored, counts continue. `start` in DONE → counters and `trace_count` read 0 on the next cycle, and `running`=1.
